// File: rtl/mod_inv_fermat_pkg.sv
// Shared types and constants for the SM2 Fermat modular-inverse controller.
package mod_inv_fermat_pkg;

    localparam int unsigned SM2_W = 256;

    typedef logic [SM2_W-1:0] word_t;

    // Default exponent: SM2 p - 2.
    localparam word_t SM2_P_M2 =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQR_REQ,
        ST_SQR_WAIT,
        ST_MUL_REQ,
        ST_MUL_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mod_inv_fermat_if.sv
// Request/response bus between the inverse controller and the modular multiplier.
interface mod_inv_fermat_if;
    import mod_inv_fermat_pkg::*;

    logic  mul_vld;
    word_t mul_a;
    word_t mul_b;
    logic  mul_fin;
    word_t mul_r;

    modport master (output mul_vld, mul_a, mul_b, input mul_fin, mul_r);
    modport slave  (input mul_vld, mul_a, mul_b, output mul_fin, mul_r);

endinterface

// File: rtl/mod_inv_fermat.sv
// Fermat modular inverse r = a^EXP mod p by left-to-right square-and-multiply,
// issuing one modular-multiply request at a time over mul_if.
module mod_inv_fermat
    import mod_inv_fermat_pkg::*;
#(
    parameter word_t       EXP     = SM2_P_M2,
    parameter int unsigned EXP_MSB = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inv_vld_i,
    input  word_t            inv_a_i,
    output logic             inv_busy_o,
    output logic             inv_fin_o,
    output word_t            inv_r_o,
    mod_inv_fermat_if.master mul_if
);

    localparam logic [7:0] IDX_START = 8'(EXP_MSB - 1);

    state_t     state_q, state_d;
    word_t      acc_q, acc_d;
    word_t      a_q, a_d;
    word_t      r_q, r_d;
    logic [7:0] idx_q, idx_d;
    logic       mul_vld;
    word_t      mul_a, mul_b;
    logic       fin;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        r_d     = r_q;
        idx_d   = idx_q;
        mul_vld = 1'b0;
        mul_a   = '0;
        mul_b   = '0;
        fin     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inv_vld_i) begin
                    a_d     = inv_a_i;
                    acc_d   = inv_a_i;
                    idx_d   = IDX_START;
                    state_d = (inv_a_i == '0 || EXP_MSB == 0) ? ST_DONE : ST_SQR_REQ;
                end
            end
            ST_SQR_REQ: begin
                mul_vld = 1'b1;
                mul_a   = acc_q;
                mul_b   = acc_q;
                state_d = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                // Operands stay on the bus until the multiplier answers.
                mul_a = acc_q;
                mul_b = acc_q;
                if (mul_if.mul_fin) begin
                    acc_d = mul_if.mul_r;
                    if (EXP[idx_q]) begin
                        state_d = ST_MUL_REQ;
                    end else if (idx_q == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - 8'd1;
                        state_d = ST_SQR_REQ;
                    end
                end
            end
            ST_MUL_REQ: begin
                mul_vld = 1'b1;
                mul_a   = acc_q;
                mul_b   = a_q;
                state_d = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                mul_a = acc_q;
                mul_b = a_q;
                if (mul_if.mul_fin) begin
                    acc_d = mul_if.mul_r;
                    if (idx_q == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - 8'd1;
                        state_d = ST_SQR_REQ;
                    end
                end
            end
            ST_DONE: begin
                fin     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Result loads on entry to DONE so it is valid alongside the done pulse.
        if (state_d == ST_DONE) r_d = acc_d;
    end

    // NOTE: the wide datapath registers are reset too, so every output is 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            r_q     <= '0;
            idx_q   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
        end
    end

    assign mul_if.mul_vld = mul_vld;
    assign mul_if.mul_a   = mul_a;
    assign mul_if.mul_b   = mul_b;
    assign inv_busy_o     = (state_q != ST_IDLE);
    assign inv_fin_o      = fin;
    assign inv_r_o        = r_q;

endmodule

// File: tb/tb_mod_inv_fermat.sv
// Self-checking bench: behavioural modmul responders with selectable latency,
// results checked as field inverses (a*r mod p == 1) and against known values.
module tb_mod_inv_fermat;
    import mod_inv_fermat_pkg::*;

    localparam word_t P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam word_t HALF_P1 =
        256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_80000000_00000000;
    localparam int MAX_CYC = 20000;

    logic  clk     = 1'b0;
    logic  rst_n   = 1'b0;
    logic  inv_vld = 1'b0;
    word_t inv_a   = '0;
    logic  busy0, fin0;
    word_t r0;
    logic  inv_vld1 = 1'b0;
    word_t inv_a1   = '0;
    logic  busy1, fin1;
    word_t r1;

    mod_inv_fermat_if mm0 ();
    mod_inv_fermat_if mm1 ();

    int    n_tests   = 0;
    int    n_fail    = 0;
    int    lat_fixed = 1;
    bit    lat_rand  = 1'b0;
    int    req_cnt0  = 0;
    int    lat_sum0  = 0;
    int    stab_err  = 0;
    word_t ops1_a[$];
    word_t ops1_b[$];

    mod_inv_fermat dut0 (
        .clk(clk), .rst_n(rst_n), .inv_vld_i(inv_vld), .inv_a_i(inv_a),
        .inv_busy_o(busy0), .inv_fin_o(fin0), .inv_r_o(r0), .mul_if(mm0.master)
    );

    mod_inv_fermat #(.EXP(256'd3), .EXP_MSB(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .inv_vld_i(inv_vld1), .inv_a_i(inv_a1),
        .inv_busy_o(busy1), .inv_fin_o(fin1), .inv_r_o(r1), .mul_if(mm1.master)
    );

    always #5 clk = ~clk;

    function automatic word_t mulmod(input word_t x, input word_t y);
        logic [511:0] t;
        t = {256'b0, x} * {256'b0, y};
        t = t % {256'b0, P};
        return t[255:0];
    endfunction

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Modmul model for dut0: answers each request after lat cycles and checks
    // that the request is held steady (no new vld, same operands) meanwhile.
    initial begin : resp0
        word_t op_a, op_b;
        int    lat;
        bit    aborted;
        mm0.mul_fin = 1'b0;
        mm0.mul_r   = '0;
        forever begin
            @(negedge clk);
            mm0.mul_fin = 1'b0;
            if (rst_n && mm0.mul_vld) begin
                req_cnt0++;
                op_a     = mm0.mul_a;
                op_b     = mm0.mul_b;
                aborted  = 1'b0;
                lat      = lat_rand ? int'($urandom_range(6, 1)) : lat_fixed;
                lat_sum0 += lat + 1;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    if (!aborted && (mm0.mul_vld !== 1'b0 || mm0.mul_a !== op_a ||
                                     mm0.mul_b !== op_b))
                        stab_err++;
                end
                mm0.mul_r   = mulmod(op_a, op_b);
                mm0.mul_fin = 1'b1;
            end
        end
    end

    // Modmul model for dut1: latency 1, records every request.
    initial begin : resp1
        word_t op_a, op_b;
        mm1.mul_fin = 1'b0;
        mm1.mul_r   = '0;
        forever begin
            @(negedge clk);
            mm1.mul_fin = 1'b0;
            if (rst_n && mm1.mul_vld) begin
                op_a = mm1.mul_a;
                op_b = mm1.mul_b;
                ops1_a.push_back(op_a);
                ops1_b.push_back(op_b);
                @(negedge clk);
                mm1.mul_r   = mulmod(op_a, op_b);
                mm1.mul_fin = 1'b1;
            end
        end
    end

    // Called at a negedge of an IDLE cycle; returns at the negedge of the
    // inv_fin_o cycle. cyc counts the accept cycle as 1.
    task automatic run0(input word_t a, input int poke_at, output word_t r, output int cyc);
        int busy_err;
        int stab_base;
        bit seen;
        busy_err  = 0;
        seen      = 1'b0;
        stab_base = stab_err;
        r         = '0;
        inv_vld   = 1'b1;
        inv_a     = a;
        cyc       = 1;
        while (!seen && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            inv_vld = (cyc == poke_at);
            inv_a   = (cyc == poke_at) ? ~a : a;
            if (!busy0) busy_err++;
            if (fin0) begin
                seen = 1'b1;
                r    = r0;
            end
        end
        check("fin_seen", word_t'(seen), 1);
        check("busy_during_run", busy_err, 0);
        check("operand_stable", stab_err - stab_base, 0);
    endtask

    task automatic idle_check(input word_t r_exp);
        @(negedge clk);
        check("busy_after_fin", busy0, 0);
        check("fin_one_cycle", fin0, 0);
        check("result_held", r0, r_exp);
    endtask

    initial begin : main
        word_t r, a;
        int    cyc, req0, ls0, poke, idle_err, cnt;
        bit    seen;

        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_fin", fin0, 0);
        check("rst_r", r0, 0);
        check("rst_mul_vld", mm0.mul_vld, 0);
        check("rst_mul_a", mm0.mul_a, 0);
        check("rst_mul_b", mm0.mul_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // a = 1, Lm = 1
        lat_rand  = 1'b0;
        lat_fixed = 1;
        req0      = req_cnt0;
        run0(1, 0, r, cyc);
        check("a1_result", r, 1);
        check("a1_requests", req_cnt0 - req0, 476);
        check("a1_latency", cyc, 954);
        idle_check(r);

        // a = 2, Lm = 7
        lat_fixed = 7;
        req0      = req_cnt0;
        run0(2, 0, r, cyc);
        check("a2_result", r, HALF_P1);
        check("a2_inverse", mulmod(2, r), 1);
        check("a2_requests", req_cnt0 - req0, 476);
        check("a2_latency", cyc, 1 + 476 * 8 + 1);
        idle_check(r);

        // zero operand, twice back-to-back
        for (int i = 0; i < 2; i++) begin
            req0 = req_cnt0;
            run0(0, 0, r, cyc);
            check("zero_result", r, 0);
            check("zero_requests", req_cnt0 - req0, 0);
            check("zero_latency", cyc, 2);
            idle_check(0);
        end

        // random operands, random per-request latency, ignored mid-run starts
        lat_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 8; k++) a[k*32 +: 32] = $urandom;
            if (a >= P) a = a - P;
            if (a == '0) a = 1;
            poke = (i % 2 == 1) ? int'($urandom_range(1000, 10)) : 0;
            req0 = req_cnt0;
            ls0  = lat_sum0;
            run0(a, poke, r, cyc);
            check("rand_inverse", mulmod(a, r), 1);
            check("rand_requests", req_cnt0 - req0, 476);
            check("rand_latency", cyc, (lat_sum0 - ls0) + 2);
            idle_check(r);
        end

        // reset at request 200 with a late modmul answer afterwards
        lat_rand  = 1'b0;
        lat_fixed = 8;
        req0      = req_cnt0;
        inv_vld   = 1'b1;
        inv_a     = 256'h1234_5678_9ABC;
        @(negedge clk);
        inv_vld = 1'b0;
        cnt     = 0;
        while (req_cnt0 - req0 < 200 && cnt < MAX_CYC) begin
            @(negedge clk);
            cnt++;
        end
        check("reached_req_200", word_t'(req_cnt0 - req0 >= 200), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_mul_vld", mm0.mul_vld, 0);
        check("abort_r", r0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        req0     = req_cnt0;
        idle_err = 0;
        repeat (16) begin
            @(negedge clk);
            if (busy0 || fin0 || mm0.mul_vld) idle_err++;
        end
        check("late_fin_ignored", idle_err, 0);
        check("no_req_after_rst", req_cnt0 - req0, 0);

        lat_fixed = 1;
        req0      = req_cnt0;
        run0(3, 0, r, cyc);
        check("a3_inverse", mulmod(3, r), 1);
        check("a3_requests", req_cnt0 - req0, 476);
        idle_check(r);

        // small exponent instance: 5^3 = 125
        inv_vld1 = 1'b1;
        inv_a1   = 5;
        @(negedge clk);
        inv_vld1 = 1'b0;
        seen     = 1'b0;
        cnt      = 0;
        r        = '0;
        while (!seen && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (fin1) begin
                seen = 1'b1;
                r    = r1;
            end
        end
        check("exp3_fin_seen", word_t'(seen), 1);
        check("exp3_result", r, 125);
        check("exp3_requests", ops1_a.size(), 2);
        if (ops1_a.size() == 2) begin
            check("exp3_sqr_a", ops1_a[0], 5);
            check("exp3_sqr_b", ops1_b[0], 5);
            check("exp3_mul_a", ops1_a[1], 25);
            check("exp3_mul_b", ops1_b[1], 5);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
